parking_lot_manager: RTL
========================

// Module: parking_lot_manager
//
// PURPOSE
//   Parametrised multi-gate parking-lot occupancy manager. Each gate has a
//   two-sensor (a/b) direction decoder FSM that emits enter/exit ticks. All
//   gates feed one saturating occupancy counter with full/empty flags, sticky
//   error flags and a 2-digit BCD free-space count for the seven-segment scan.
//   Sits after the button debouncers and before the display scan logic.
//
// PARAMETERS
//   N_GATES   2    number of independent gates (1..8)
//   CAPACITY  15   lot capacity in cars (1..99)
//   CNT_W     $clog2(CAPACITY+1)  occupancy width (derived; do not override)
//
// PORTS
//   clk        in   1          system clock
//   rst        in   1          synchronous reset, active-high
//   a          in   N_GATES    outer sensor per gate, debounced, active-high
//   b          in   N_GATES    inner sensor per gate, debounced, active-high
//   enter_tick out  N_GATES    1-cycle pulse: car completed entry at gate i
//   exit_tick  out  N_GATES    1-cycle pulse: car completed exit at gate i
//   occupancy  out  CNT_W      cars currently in lot
//   full       out  1          occupancy == CAPACITY
//   empty      out  1          occupancy == 0
//   ovf_err    out  1          sticky: entry clamped at CAPACITY
//   unf_err    out  1          sticky: exit clamped at 0
//   free_bcd   out  8          CAPACITY-occupancy, {tens,ones} BCD
//
// BEHAVIOUR
//   Reset (rst=1 at posedge): every gate FSM -> IDLE; ticks 0; occupancy 0;
//     empty 1; full 0; ovf_err/unf_err 0; free_bcd = BCD(CAPACITY).
//     Reset mid-sequence discards partial passage, no tick.
//   Gate FSM (per gate, sampled each clk; ab = {a[i],b[i]}):
//     IDLE: 10->EN1; 01->EX1; 11/00 stay.
//     EN1: 11->EN2; 00->IDLE (abort); else stay.
//     EN2: 01->EN3; 10->EN1; 00->IDLE; 11 stay.
//     EN3: 00->IDLE + enter_tick; 11->EN2; 10->IDLE (abort); 01 stay.
//     EX1/EX2/EX3: mirror of EN1..3 with a<->b; EX3 00->IDLE + exit_tick.
//   Tick is registered: high exactly the cycle after 00 is sampled in EN3/EX3.
//   Counter (latency 1 cycle after tick): E = popcount(enter_tick),
//     X = popcount(exit_tick); s = occupancy + E - X in signed CNT_W+4 bits.
//     s > CAPACITY -> occupancy = CAPACITY, ovf_err <= 1.
//     s < 0        -> occupancy = 0, unf_err <= 1.
//     else occupancy = s. Simultaneous enters/exits net first, then clamp
//     (full lot with 1 enter + 1 exit same cycle: no change, no error).
//   full/empty/free_bcd combinational from occupancy register.
//   Error flags cleared only by rst.
//
// TESTING
//   1. rst, gate0 a/b = 10,11,01,00 -> enter_tick[0] 1 cycle, occupancy 1,
//      free_bcd 8'h14 (CAPACITY=15).
//   2. gate0 = 01,11,10,00 from occupancy 1 -> exit_tick[0], occupancy 0,
//      empty 1; one more exit -> occupancy 0, unf_err 1.
//   3. Aborted entry 10,11,10,00 -> no tick, occupancy unchanged.
//   4. 15 entries -> full 1, free_bcd 8'h00; 16th -> occupancy 15, ovf_err 1.
//   5. Occupancy 15, gate0 enter + gate1 exit same cycle -> occupancy 15,
//      no error; both gates enter from 5 -> occupancy 7.
//   6. rst asserted in EN2 -> FSM IDLE, ticks 0, then 00 gives no tick.

Source files
------------

// File: rtl/parking_lot_manager.sv
// ----------------------------------------------------------------------------
// parking_lot_manager
//
// Multi-gate parking-lot occupancy manager. Every gate has a two-sensor
// direction decoder (outer sensor a, inner sensor b) that recognises a full
// entry (a, ab, b, none) or exit (b, ab, a, none) passage and emits a one-cycle
// registered tick. All gate ticks feed a single saturating occupancy counter.
// The counter drives full/empty flags, sticky overflow/underflow flags and a
// two-digit BCD free-space count for the seven-segment scan logic.
//
// Ports
//   clk         in   1        system clock
//   rst         in   1        synchronous reset, active-high
//   a           in   N_GATES  outer sensor per gate (debounced, active-high)
//   b           in   N_GATES  inner sensor per gate (debounced, active-high)
//   enter_tick  out  N_GATES  1-cycle pulse: car completed entry at gate i
//   exit_tick   out  N_GATES  1-cycle pulse: car completed exit at gate i
//   occupancy   out  CNT_W    cars currently in the lot
//   full        out  1        occupancy == CAPACITY
//   empty       out  1        occupancy == 0
//   ovf_err     out  1        sticky: an entry was clamped at CAPACITY
//   unf_err     out  1        sticky: an exit was clamped at 0
//   free_bcd    out  8        CAPACITY - occupancy as {tens, ones} BCD
// ----------------------------------------------------------------------------
module parking_lot_manager #(
    parameter int N_GATES  = 2,
    parameter int CAPACITY = 15,
    parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_GATES-1:0] a,
    input  logic [N_GATES-1:0] b,
    output logic [N_GATES-1:0] enter_tick,
    output logic [N_GATES-1:0] exit_tick,
    output logic [CNT_W-1:0]   occupancy,
    output logic               full,
    output logic               empty,
    output logic               ovf_err,
    output logic               unf_err,
    output logic [7:0]         free_bcd
);

    // Signed width wide enough for occupancy plus up to 8 simultaneous ticks
    // in either direction, so the net sum never wraps before clamping.
    localparam int SUM_W = CNT_W + 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EN1,
        ST_EN2,
        ST_EN3,
        ST_EX1,
        ST_EX2,
        ST_EX3
    } gate_state_e;

    // ------------------------------------------------------------------------
    // Per-gate direction decoders
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < N_GATES; gi++) begin : g_gate
        gate_state_e state_q;
        logic        enter_q;
        logic        exit_q;
        logic [1:0]  ab;

        assign ab = {a[gi], b[gi]};

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                enter_q <= 1'b0;
                exit_q  <= 1'b0;
            end else begin
                enter_q <= 1'b0;
                exit_q  <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (ab == 2'b10)      state_q <= ST_EN1;
                        else if (ab == 2'b01) state_q <= ST_EX1;
                    end
                    // Entry path: a, a&b, b, clear
                    ST_EN1: begin
                        if (ab == 2'b11)      state_q <= ST_EN2;
                        else if (ab == 2'b00) state_q <= ST_IDLE;
                    end
                    ST_EN2: begin
                        case (ab)
                            2'b01:   state_q <= ST_EN3;
                            2'b10:   state_q <= ST_EN1;
                            2'b00:   state_q <= ST_IDLE;
                            default: state_q <= ST_EN2;
                        endcase
                    end
                    ST_EN3: begin
                        case (ab)
                            2'b00: begin
                                state_q <= ST_IDLE;
                                enter_q <= 1'b1;
                            end
                            2'b11:   state_q <= ST_EN2;
                            2'b10:   state_q <= ST_IDLE; // backed out
                            default: state_q <= ST_EN3;
                        endcase
                    end
                    // Exit path: b, a&b, a, clear
                    ST_EX1: begin
                        if (ab == 2'b11)      state_q <= ST_EX2;
                        else if (ab == 2'b00) state_q <= ST_IDLE;
                    end
                    ST_EX2: begin
                        case (ab)
                            2'b10:   state_q <= ST_EX3;
                            2'b01:   state_q <= ST_EX1;
                            2'b00:   state_q <= ST_IDLE;
                            default: state_q <= ST_EX2;
                        endcase
                    end
                    ST_EX3: begin
                        case (ab)
                            2'b00: begin
                                state_q <= ST_IDLE;
                                exit_q  <= 1'b1;
                            end
                            2'b11:   state_q <= ST_EX2;
                            2'b01:   state_q <= ST_IDLE; // backed out
                            default: state_q <= ST_EX3;
                        endcase
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end

        assign enter_tick[gi] = enter_q;
        assign exit_tick[gi]  = exit_q;
    end

    // ------------------------------------------------------------------------
    // Occupancy counter: net all gate ticks first, then clamp
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]        occupancy_q, occupancy_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic signed [SUM_W-1:0] n_enter;
    logic signed [SUM_W-1:0] n_exit;
    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W-1:0] cap_s;

    assign cap_s = $signed(SUM_W'(CAPACITY));

    always_comb begin
        n_enter = '0;
        n_exit  = '0;
        for (int i = 0; i < N_GATES; i++) begin
            n_enter = n_enter + $signed(SUM_W'(enter_tick[i]));
            n_exit  = n_exit  + $signed(SUM_W'(exit_tick[i]));
        end
        sum_s = $signed({4'b0000, occupancy_q}) + n_enter - n_exit;

        occupancy_d = sum_s[CNT_W-1:0];
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        if (sum_s > cap_s) begin
            occupancy_d = CNT_W'(CAPACITY);
            ovf_d       = 1'b1;
        end else if (sum_s[SUM_W-1]) begin
            occupancy_d = '0;
            unf_d       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy_q <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            occupancy_q <= occupancy_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // ------------------------------------------------------------------------
    // Status and display outputs, decoded from the occupancy register
    // ------------------------------------------------------------------------
    logic [6:0] free_w;

    assign free_w    = 7'(CAPACITY) - 7'(occupancy_q);
    assign free_bcd  = {4'(free_w / 7'd10), 4'(free_w % 7'd10)};
    assign occupancy = occupancy_q;
    assign full      = (occupancy_q == CNT_W'(CAPACITY));
    assign empty     = (occupancy_q == '0);
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;

endmodule
